cic_interp_hs: RTL
==================

# cic_interp_hs

Runtime-rate CIC interpolator for the transmit path, sitting between the baseband sample source and the DAC-rate datapath. Accepts input samples through a valid/ready handshake and paces them internally with a phase counter driven by `strobe_out`. Applies gain normalisation with round-half-up and saturation on the output. Reports underruns instead of silently repeating data.

## Interface
Parameters:
- `BW`, 18: sample width, two's complement, input and output.
- `N`, 4: number of comb and integrator stages (N ≥ 1).
- `LOG2_MAX_RATE`, 7: log2 of the maximum interpolation rate. `MAXR = 2**LOG2_MAX_RATE`.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, all state is synchronously cleared.
- `rate` in LOG2_MAX_RATE+1: interpolation rate R, valid range 1..MAXR.
- `strobe_out` in 1: output-rate tick, one cycle wide.
- `in_valid` in 1: input sample offered.
- `in_ready` out 1: block can accept a sample.
- `signal_in` in BW: input sample.
- `out_valid` out 1: new `signal_out` this cycle.
- `signal_out` out BW: normalised output sample.
- `underrun` out 1: sticky flag; set when a sample was needed and none was buffered.

## Operation
- **Internal width.** `W = BW + (N-1)*LOG2_MAX_RATE`. Internal arithmetic wraps modulo 2^W. The input is sign-extended to W.
- **Rate capture.** `rate` is captured on the first cycle `enable` is high after being low, or after reset.
  - Captured value 0 is treated as 1.
  - Captured values above MAXR clamp to MAXR.
  - Later `rate` changes are ignored until `enable` is deasserted and reasserted.
- **Normalisation shift.** `S = (N-1)*ceil(log2(R))`, computed once at capture.
- **Input buffer.** One entry.
  - `in_ready = enable & ~buf_full`, registered.
  - On `in_valid & in_ready` the buffer loads `signal_in` and `buf_full` is set.
- **Phase counter.** Range 0..R-1. It advances on each `strobe_out` and wraps to 0 after R-1.
- **Consume event.** A consume event is `strobe_out` while phase == 0.
  - If the buffer is full: comb input = buffer contents, and `buf_full` clears.
  - If the buffer is empty: comb input = 0 and `underrun` is set.
  - If a load and a consume land on the same cycle with the buffer empty, the consume still underruns. The loaded sample is kept for the next consume.
- **Comb section.** N stages, updated only on consume events. Each stage: `out <= x - delay; delay <= x`.
- **Integrator section.** N stages, updated on every `strobe_out`.
  - Integrator 0 adds the comb output register only on consume events and adds 0 otherwise (zero-stuffing).
  - Integrator k (k ≥ 1) adds the previous-cycle value of integrator k-1.
- **Output normalisation.** Let x = integrator[N-1] and S the normalisation shift.
  - If S > 0: y = (x + 2^(S-1)) >>> S.
  - If S = 0: y = x.
  - y is then saturated to the BW range, [-2^(BW-1), 2^(BW-1)-1].
  - DC gain = R^(N-1) / 2^S, which is ≤ 1 and exactly 1 when R is a power of two.
- **Enable low.** Clears comb, integrators, phase, buffer, `underrun`, `signal_out` and `out_valid`, and drives `in_ready` to 0.
- **Reset values.** All outputs are 0 and all internal state is 0.

## Timing
- `strobe_out` in cycle k updates the integrators at the end of cycle k. `signal_out` and `out_valid` are both registered and present the result in cycle k+2. `out_valid` is high for exactly that one cycle.
- An input consumed in cycle k first affects integrator 0 at the next consume event, because integrator 0 uses the pre-update comb output. From that point it propagates through integrator k after k further `strobe_out`s.
- After a load, `in_ready` goes low the following cycle. After a consume, it returns high the following cycle.
- Asynchronous `reset_n` assertion mid-operation clears everything immediately. The block restarts with phase 0 on the first `strobe_out` after release with `enable` high.

## Test plan
- **Impulse response.** N=2, R=4, one sample of 1000 then zeros, `strobe_out` every 3 clocks, buffer kept fed. Required `signal_out` sequence: 250, 500, 750, 1000, 750, 500, 250, then 0. Each `out_valid` is 2 clocks after its strobe.
- **DC gain, power-of-two rate.** Defaults, R=8, constant input 1000. Output settles at exactly 1000. Constant input -131072 settles at -131072 with no wrap.
- **DC gain, non-power-of-two rate.** R=5 with N=4 (S=9, gain 125/512), constant input 1000. Output settles at 244.
- **Handshake and underrun.**
  - `in_valid` held high: exactly one acceptance per R strobes, and `underrun` stays 0.
  - Withhold input across one consume: `underrun` rises in the cycle after that consume and the comb sees 0.
  - Deassert `enable`: `underrun` clears.
- **Rate capture.** Change `rate` from 4 to 8 while enabled: the acceptance spacing stays at 4 strobes. Toggle `enable` low then high: spacing becomes 8. Set `rate=0`: behaves as R=1, passthrough with one acceptance per strobe.
- **Mid-run reset.** Assert `reset_n=0` mid-stream. All outputs go to 0 asynchronously. After release, the first output sequence matches the impulse test from a fresh start.

Source files
------------

// File: rtl/cic_interp_hs.sv
// Runtime-rate CIC interpolator: one-entry handshake buffer, strobe-paced phase
// counter, comb/integrator chain and round-half-up, saturating gain normalisation.
module cic_interp_hs #(
    parameter int BW            = 18,
    parameter int N             = 4,
    parameter int LOG2_MAX_RATE = 7
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [LOG2_MAX_RATE:0] rate,
    input  logic                   strobe_out,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BW-1:0]          signal_in,
    output logic                   out_valid,
    output logic [BW-1:0]          signal_out,
    output logic                   underrun
);

    localparam int W  = BW + (N - 1) * LOG2_MAX_RATE;
    localparam int RW = LOG2_MAX_RATE + 1;
    localparam int PW = (LOG2_MAX_RATE > 0) ? LOG2_MAX_RATE : 1;
    localparam int SW = $clog2((N - 1) * LOG2_MAX_RATE + 2);

    localparam logic [RW-1:0]       MAXR   = RW'(1) << LOG2_MAX_RATE;
    localparam logic signed [W:0]   SAT_HI = $signed({{(W-BW+2){1'b0}}, {(BW-1){1'b1}}});
    localparam logic signed [W:0]   SAT_LO = $signed({{(W-BW+2){1'b1}}, {(BW-1){1'b0}}});

    // Normalisation shift (N-1)*ceil(log2(r)) for an already clamped rate.
    function automatic logic [SW-1:0] norm_shift(input logic [RW-1:0] r);
        logic [SW-1:0] c;
        logic [RW-1:0] p;
        c = '0;
        for (int i = 0; i < LOG2_MAX_RATE; i++) begin
            p = RW'(1 << i);
            if (r > p) c = SW'(i + 1);
        end
        return SW'((N - 1) * int'(c));
    endfunction

    logic                   captured;
    logic [RW-1:0]          r_cap;
    logic [SW-1:0]          s_cap;
    logic [RW-1:0]          rate_clamped;
    logic [RW-1:0]          r_eff;
    logic [PW-1:0]          phase;
    logic                   phase_wrap;
    logic                   buf_full;
    logic                   buf_full_n;
    logic signed [BW-1:0]   buf_data;
    logic                   load;
    logic                   consume;
    logic                   strobe_d;
    logic signed [W-1:0]    comb_dly [N];
    logic signed [W-1:0]    comb_x   [N+1];
    logic signed [W-1:0]    comb_q;
    logic signed [W-1:0]    integ    [N];
    logic signed [W:0]      x_ext;
    logic signed [W:0]      rnd;
    logic signed [W:0]      y_full;
    logic [BW-1:0]          y_sat;

    always_comb begin
        rate_clamped = rate;
        if (rate == '0)
            rate_clamped = RW'(1);
        else if (rate > MAXR)
            rate_clamped = MAXR;
    end

    // Until the capture cycle has registered, the clamped live rate is the one in force.
    assign r_eff      = captured ? r_cap : rate_clamped;
    assign phase_wrap = (RW'(phase) == (r_eff - RW'(1)));
    assign load       = in_valid & in_ready;
    assign consume    = enable & strobe_out & (phase == '0);
    assign buf_full_n = load ? 1'b1 : (consume ? 1'b0 : buf_full);

    always_comb begin
        comb_x[0] = buf_full ? W'(buf_data) : '0;
        for (int k = 0; k < N; k++)
            comb_x[k+1] = comb_x[k] - comb_dly[k];
    end

    always_comb begin
        x_ext  = {integ[N-1][W-1], integ[N-1]};
        rnd    = (s_cap == '0) ? '0 : ((W+1)'(1) << (s_cap - SW'(1)));
        y_full = (x_ext + rnd) >>> s_cap;
        if (y_full > SAT_HI)
            y_sat = SAT_HI[BW-1:0];
        else if (y_full < SAT_LO)
            y_sat = SAT_LO[BW-1:0];
        else
            y_sat = y_full[BW-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            captured   <= 1'b0;
            r_cap      <= '0;
            s_cap      <= '0;
            phase      <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            in_ready   <= 1'b0;
            underrun   <= 1'b0;
            comb_q     <= '0;
            strobe_d   <= 1'b0;
            out_valid  <= 1'b0;
            signal_out <= '0;
            for (int k = 0; k < N; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else if (!enable) begin
            captured   <= 1'b0;
            r_cap      <= '0;
            s_cap      <= '0;
            phase      <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            in_ready   <= 1'b0;
            underrun   <= 1'b0;
            comb_q     <= '0;
            strobe_d   <= 1'b0;
            out_valid  <= 1'b0;
            signal_out <= '0;
            for (int k = 0; k < N; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else begin
            captured <= 1'b1;
            if (!captured) begin
                r_cap <= rate_clamped;
                s_cap <= norm_shift(rate_clamped);
            end

            buf_full <= buf_full_n;
            in_ready <= ~buf_full_n;
            if (load)
                buf_data <= signal_in;

            if (strobe_out)
                phase <= phase_wrap ? '0 : phase + PW'(1);

            // An empty buffer feeds zero into the combs and latches the underrun.
            if (consume) begin
                for (int k = 0; k < N; k++)
                    comb_dly[k] <= comb_x[k];
                comb_q <= comb_x[N];
                if (!buf_full)
                    underrun <= 1'b1;
            end

            if (strobe_out) begin
                integ[0] <= integ[0] + (consume ? comb_q : '0);
                for (int k = 1; k < N; k++)
                    integ[k] <= integ[k] + integ[k-1];
            end

            strobe_d  <= strobe_out;
            out_valid <= strobe_d;
            if (strobe_d)
                signal_out <= y_sat;
        end
    end

endmodule
